mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters of the 5-stage pipeline: the IF-stage instruction fetch and the MEM-stage load/store.
- Issues one memory access at a time and waits a fixed memory latency for each.
- Returns read data with a one-cycle valid pulse.
- Produces per-stage stall signals that the pipeline uses to hold the PC/IF-ID registers and the EX/MEM registers.

Parameters:
ADDR_W, 32, address width of both requesters and the memory.
DATA_W, 32, data width.
MEM_LAT, 2, cycles from the access-issue cycle to the cycle mem_rdata is valid; legal values 1..15.
STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending before the fetch is forced.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
if_req  in  1  fetch request; held with if_addr stable until if_valid.
if_addr  in  ADDR_W  fetch address (PC).
if_rdata  out  DATA_W  fetched instruction; registered, held until next fetch completes.
if_valid  out  1  one-cycle pulse: fetch complete.
dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata stable until dm_valid.
dm_we  in  1  1 = store, 0 = load.
dm_addr  in  ADDR_W  data address (ALU result).
dm_wdata  in  DATA_W  store data.
dm_rdata  out  DATA_W  load data; registered, held until next data access completes.
dm_valid  out  1  one-cycle pulse: load or store complete.
mem_en  out  1  memory access strobe, asserted for exactly the issue cycle.
mem_we  out  1  write enable; qualified by mem_en.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the issue cycle.
stall_if  out  1  if_req & ~if_valid (combinational).
stall_mem  out  1  dm_req & ~dm_valid (combinational).
busy  out  1  1 in WAIT or RESP.

Behaviour:
Reset values (while reset=0, asynchronous):
- State IDLE; all valids, mem_en, mem_we and busy are 0.
- rdata registers, latency counter and starvation counter are 0.

States:
- IDLE: if any request is pending, issue it this cycle and go to WAIT.
  - Issue means: mem_en=1, and mem_addr/mem_we/mem_wdata are driven combinationally from the winner. A fetch drives mem_we=0.
  - Latch the grant owner; load the latency counter with MEM_LAT-1.
  - If MEM_LAT=1, go directly to RESP.
  - With no request, mem_en=0 and the mem_* outputs are don't-care (driven 0).
- WAIT: decrement the counter each cycle; when it reaches 0, go to RESP. mem_en=0.
- RESP: the cycle mem_rdata is valid.
  - The owner's valid is 1 this cycle.
  - The owner's rdata register captures mem_rdata at the closing edge. The rdata output passes mem_rdata through during RESP, then shows the register value.
  - A store sets dm_valid the same way; dm_rdata is left unchanged.
  - Next state is IDLE; no new issue during RESP.
- Latency: issue at cycle T, valid at cycle T+MEM_LAT. Earliest next issue is T+MEM_LAT+1.

Arbitration in IDLE:
- Data has priority over fetch (the older instruction wins).
- Starvation counter:
  - Increments on each data grant made while if_req=1, saturating at STARVE_MAX.
  - Clears on any fetch grant, and on any data grant made while if_req=0.
- When the counter equals STARVE_MAX and if_req=1, the fetch wins regardless of dm_req.

Boundary conditions:
- A request deasserted before its valid is a protocol violation. The access still completes and the valid still pulses.
- A request that appears during WAIT/RESP waits; its stall signal stays asserted.
- Asynchronous reset mid-access abandons the transaction. Valids stay 0 and the next access starts from IDLE. A store already issued is not undone.
- Address wrap-around is the memory's responsibility; addresses pass through unmodified.

Test Plan:
1. Single fetch, MEM_LAT=2: if_req=1, if_addr=0x40 at cycle 0, memory returns 0x8C010004 at cycle 2 → mem_en=1 only at cycle 0 with mem_addr=0x40, mem_we=0; if_valid=1 only at cycle 2; if_rdata=0x8C010004 from cycle 2 onward; stall_if=1 for cycles 0–1.
2. Simultaneous requests: if_req=1 (addr 0x44) and dm_req=1 load (addr 0x100) at cycle 0 → data issued at cycle 0, dm_valid at cycle 2; fetch issued at cycle 3, if_valid at cycle 5.
3. Store: dm_req=1, dm_we=1, dm_addr=0x200, dm_wdata=0xDEADBEEF → mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF in the issue cycle; dm_valid 2 cycles later; dm_rdata unchanged.
4. Starvation, STARVE_MAX=4: dm_req held high with a new access after each dm_valid, if_req high throughout → 4 data grants, then 1 fetch grant, then data grants resume.
5. Reset mid-access: assert reset=0 during WAIT of a load, release 1 cycle later → no dm_valid for that load; busy=0; the next dm_req is issued from IDLE with full MEM_LAT latency.
6. MEM_LAT=1: back-to-back fetches with if_req held high → issues on cycles 0, 2, 4; if_valid on cycles 1, 3, 5.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the IF-stage fetch and the MEM-stage load/store.
// One access in flight at a time; data wins unless a pending fetch has been passed over STARVE_MAX times.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state, w_next;
  logic              r_own_dm;
  logic              r_we;
  logic [3:0]        r_cnt;
  logic [SW-1:0]     r_starve;
  logic [DATA_W-1:0] r_if_rdata, r_dm_rdata;
  logic              w_starved, w_grant_dm, w_grant_if, w_issue, w_sat;

  // Handshake: a requester raises *_req with stable payload and holds it until
  // its *_valid pulse; the valid pulse is the only completion indication.
  assign w_sat      = (r_starve == SW'(STARVE_MAX));
  assign w_starved  = if_req && w_sat;
  assign w_grant_dm = dm_req && !w_starved;
  assign w_grant_if = if_req && !w_grant_dm;
  assign w_issue    = reset && (r_state == S_IDLE) && (w_grant_dm || w_grant_if);

  always_comb begin
    w_next    = r_state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_valid  = 1'b0;
    dm_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          mem_en = 1'b1;
          if (w_grant_dm) begin
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
          end else begin
            mem_addr = if_addr;
          end
          w_next = (MEM_LAT == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        // The counter value 1 here means read data lands next cycle.
        if (r_cnt <= 4'd1) w_next = S_RESP;
      end
      S_RESP: begin
        if_valid = !r_own_dm;
        dm_valid = r_own_dm;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_own_dm   <= 1'b0;
      r_we       <= 1'b0;
      r_cnt      <= '0;
      r_starve   <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_own_dm <= w_grant_dm;
        r_we     <= w_grant_dm && dm_we;
        r_cnt    <= 4'(MEM_LAT - 1);
        if (w_grant_dm && if_req) r_starve <= w_sat ? r_starve : r_starve + SW'(1);
        else                      r_starve <= '0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == S_RESP) begin
        if (!r_own_dm)  r_if_rdata <= mem_rdata;
        else if (!r_we) r_dm_rdata <= mem_rdata;
      end
    end
  end

  // Read data is forwarded in the response cycle so the pipeline can use it immediately.
  assign if_rdata  = (r_state == S_RESP && !r_own_dm)         ? mem_rdata : r_if_rdata;
  assign dm_rdata  = (r_state == S_RESP && r_own_dm && !r_we) ? mem_rdata : r_dm_rdata;
  assign stall_if  = if_req && !if_valid;
  assign stall_mem = dm_req && !dm_valid;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: random fetch/data requesters, a behavioural memory, and a
// rule-level arbitration model feeding an expected-response queue checked by a monitor.
module tb_mem_port_arbiter;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;
  localparam int W          = 49;

  logic        clk, reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_valid, dm_valid, mem_en, mem_we, stall_if, stall_mem, busy;
  logic [1:0]  dbg_state;

  logic        if_req1;
  logic [31:0] if_addr1, mem_rdata1, if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;
  logic        if_valid1, dm_valid1, mem_en1, mem_we1, stall_if1, stall_mem1, busy1;
  logic [1:0]  dbg_state1;
  logic        zero_bit;
  logic [31:0] zero_word;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W-1:0]  exp_q[$];
  logic [31:0]   mem_arr[logic [31:0]];
  int            next_free  = 0;
  int            last_issue = -100;
  int            starve     = 0;
  int            due_cyc    = -1;
  logic [31:0]   pend_data;
  logic [31:0]   m_if_rdata, m_dm_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy),
    .dbg_state(dbg_state)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(STARVE_MAX)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_valid(if_valid1),
    .dm_req(zero_bit), .dm_we(zero_bit), .dm_addr(zero_word), .dm_wdata(zero_word),
    .dm_rdata(dm_rdata1), .dm_valid(dm_valid1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .stall_if(stall_if1), .stall_mem(stall_mem1), .busy(busy1),
    .dbg_state(dbg_state1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic logic [31:0] mem_read(logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  // Behavioural memory: read data appears exactly MEM_LAT cycles after the issue cycle.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (cyc == due_cyc) mem_rdata = pend_data;
    else                mem_rdata = $urandom;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic          exp_issue, dm_win;
    logic [31:0]   exp_data;
    logic [W-1:0]  e;
    if (!reset) begin
      exp_q.delete();
      next_free  = 0;
      last_issue = -100;
      starve     = 0;
      m_if_rdata = '0;
      m_dm_rdata = '0;
      chk("rst_quiet", {mem_en, mem_we, if_valid, dm_valid, busy}, 0);
      chk("rst_rdata", {if_rdata, dm_rdata}, 0);
      chk("rst_state", dbg_state, 0);
    end else begin
      chk("stall", {stall_if, stall_mem}, {if_req & ~if_valid, dm_req & ~dm_valid});
      chk("busy", busy, (cyc > last_issue) && (cyc <= last_issue + MEM_LAT));
      exp_issue = (cyc >= next_free) && (if_req || dm_req);
      chk("mem_en", mem_en, exp_issue);
      if (exp_issue) begin
        dm_win = dm_req && !(starve == STARVE_MAX && if_req);
        if (dm_win) begin
          chk("issue_dm_addr", mem_addr, dm_addr);
          chk("issue_dm_we", mem_we, dm_we);
          if (dm_we) chk("issue_wdata", mem_wdata, dm_wdata);
          exp_data = dm_we ? m_dm_rdata : mem_read(dm_addr);
          starve   = if_req ? ((starve < STARVE_MAX) ? starve + 1 : starve) : 0;
        end else begin
          chk("issue_if_addr", mem_addr, if_addr);
          chk("issue_if_we", mem_we, 0);
          exp_data = mem_read(if_addr);
          starve   = 0;
        end
        exp_q.push_back({16'(cyc + MEM_LAT), dm_win, exp_data});
        last_issue = cyc;
        next_free  = cyc + MEM_LAT + 1;
      end
      if (mem_en) begin
        pend_data = mem_read(mem_addr);
        if (mem_we) mem_arr[mem_addr] = mem_wdata;
        due_cyc = cyc + MEM_LAT;
      end
      if (if_valid || dm_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {if_valid, dm_valid}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_time", cyc, int'(e[48:33]));
          chk("resp_owner", {if_valid, dm_valid}, e[32] ? 2'b01 : 2'b10);
          if (e[32]) begin
            chk("resp_dm_rdata", dm_rdata, e[31:0]);
            m_dm_rdata = e[31:0];
          end else begin
            chk("resp_if_rdata", if_rdata, e[31:0]);
            m_if_rdata = e[31:0];
          end
        end
      end else if (exp_q.size() > 0 && cyc > int'(exp_q[0][48:33])) begin
        e = exp_q.pop_front();
        chk("resp_timeout", 0, 1);
      end
      if (!if_valid) chk("if_rdata_hold", if_rdata, m_if_rdata);
      if (!dm_valid) chk("dm_rdata_hold", dm_rdata, m_dm_rdata);
    end
  end

  // ---------------- driver tasks (called at posedge + #1) ----------------
  task automatic fetch_txn(input logic [31:0] a);
    logic got = 1'b0;
    if_req = 1'b1; if_addr = a;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (if_valid) begin got = 1'b1; break; end
    end
    chk("fetch_wait", got, 1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic data_txn(input logic we, input logic [31:0] a, input logic [31:0] wd);
    logic got = 1'b0;
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dm_valid) begin got = 1'b1; break; end
    end
    chk("data_wait", got, 1);
    @(posedge clk); #1;
    dm_req = 1'b0;
  endtask

  function automatic logic [31:0] rnd_addr();
    return {24'h0, 6'($urandom_range(0, 63)), 2'b00};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    if_req1 = 1'b0; if_addr1 = 32'h80; mem_rdata1 = '0;
    zero_bit = 1'b0; zero_word = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    fetch_txn(32'h40);
    fork
      fetch_txn(32'h44);
      data_txn(1'b0, 32'h100, 32'h0);
    join
    data_txn(1'b1, 32'h200, 32'hDEADBEEF);
    data_txn(1'b0, 32'h200, 32'h0);

    // Fetch held while data streams back-to-back.
    fork
      fetch_txn(32'h48);
      begin
        for (int k = 0; k < 7; k++) data_txn(k[0], 32'h300 + 32'(k * 4), $urandom);
      end
    join

    // Reset in the WAIT state of a load.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3C;
    @(posedge clk); #1;
    reset = 1'b0; dm_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    data_txn(1'b0, 32'h3C, 32'h0);

    fork
      begin
        for (int n = 0; n < 30; n++) begin
          repeat ($urandom_range(0, 4)) @(posedge clk);
          #1 fetch_txn(rnd_addr());
        end
      end
      begin
        for (int n = 0; n < 30; n++) begin
          repeat ($urandom_range(0, 4)) @(posedge clk);
          #1 data_txn(1'($urandom_range(0, 1)), rnd_addr(), $urandom);
        end
      end
    join
    repeat (8) @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 0);

    // MEM_LAT=1 instance: fetch held high gives issue/valid alternating every cycle.
    if_req1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      mem_rdata1 = 32'hC0DE0000 + 32'(k);
      @(negedge clk);
      chk("l1_mem_en", mem_en1, (k % 2) == 0);
      chk("l1_valid", if_valid1, (k % 2) == 1);
      if (k % 2 == 0) chk("l1_addr", mem_addr1, 32'h80);
      if (k > 0) chk("l1_rdata", if_rdata1, 32'hC0DE0000 + 32'((k % 2 == 1) ? k : k - 1));
      @(posedge clk); #1;
    end
    if_req1 = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
